// File: rtl/gpu_sched_pkg.sv
// Shared types and header layout for the frame dispatcher.
// Optional SCHED_PERF_EN adds perf counters to frame_dispatcher.
package gpu_sched_pkg;

  typedef enum logic [1:0] {
    KIND_MASK   = 2'd0,
    KIND_R0VEC  = 2'd1,
    KIND_R0DATA = 2'd2,
    KIND_INSTR  = 2'd3
  } msg_kind_e;

  typedef enum logic [1:0] {
    FENCE_NONE = 2'd0,
    FENCE_ACQ  = 2'd1,
    FENCE_REL  = 2'd2,
    FENCE_RSVD = 2'd3
  } fence_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_CHECK,
    S_MASK,
    S_R0VEC,
    S_R0,
    S_IF,
    S_NEXT,
    S_DONE
  } state_e;

  localparam int HDR_WORDS     = 3;
  localparam int HDR_MASK_OFF  = 1;
  localparam int HDR_R0VEC_OFF = 2;
  localparam int HDR_IF_LSB    = 0;
  localparam int HDR_FENCE_W   = 2;

endpackage

// File: rtl/sched_prog_mem.sv
// Program memory: one write port, one registered read port.
// Read data only updates when re is high, so it holds a beat.
module sched_prog_mem #(
  parameter int DEPTH = 1024,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_dispatcher.sv
// Streams task frames from program memory to the core array.
// Define SCHED_PERF_EN to add perf_stall_cyc / perf_tasks ports.
module frame_dispatcher
  import gpu_sched_pkg::*;
#(
  parameter int DATA_DEPTH  = 1024,
  parameter int WORD_W      = 16,
  parameter int CORE_NUM    = 16,
  parameter int R0_DEPTH    = 8,
  parameter int FRAME_WORDS = 16,
  parameter int IF_MAX      = 63,
  localparam int ADDR_W     = $clog2(DATA_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [WORD_W-1:0]   ld_data,
  input  logic                start,
  input  logic [CORE_NUM-1:0] core_busy,
  output logic [WORD_W-1:0]   msg_data,
  output logic [1:0]          msg_kind,
  output logic                msg_last,
  output logic                msg_valid,
  input  logic                msg_ready,
  output logic                active,
  output logic                done,
  output logic                err
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]         perf_stall_cyc,
  output logic [15:0]         perf_tasks
`endif
);

  localparam int IF_W = $clog2(IF_MAX + 1);
  localparam int FW_W = $clog2(FRAME_WORDS) + 1;
  localparam int EW   = ADDR_W + IF_W + FW_W + 1;

  state_e              state, state_n;
  msg_kind_e           kind;
  fence_e              fence;
  logic [1:0]          hdr_cnt;
  logic [ADDR_W-1:0]   base, ptr;
  logic [ADDR_W-1:0]   mem_raddr;
  logic [ADDR_W-1:0]   last_r0, last_if;
  logic                mem_re, mem_we;
  logic [WORD_W-1:0]   rd_data;
  logic [WORD_W-1:0]   word0, exec_mask, r0_vec;
  logic [CORE_NUM-1:0] prev_mask;
  logic [IF_W-1:0]     if_cnt;
  logic [EW-1:0]       task_end;
  logic                hdr_halt, hdr_ovf;
  logic                stall, fire;

  sched_prog_mem #(
    .DEPTH (DATA_DEPTH),
    .W     (WORD_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rd_data)
  );

  assign if_cnt = word0[HDR_IF_LSB +: IF_W];
  assign fence  = fence_e'(word0[IF_W +: HDR_FENCE_W]);

  assign task_end = EW'(base)
                  + (EW'(if_cnt) + EW'(1))
                  * EW'(FRAME_WORDS);

  // The following header must also land inside memory.
  assign hdr_halt = (word0 == '0);
  assign hdr_ovf  = task_end >= EW'(DATA_DEPTH);

  assign last_r0 = base
                 + ADDR_W'(HDR_WORDS + R0_DEPTH - 1);
  assign last_if = task_end[ADDR_W-1:0] - ADDR_W'(1);

  assign active = (state != S_IDLE)
               && (state != S_DONE);
  assign mem_we = ld_we & ~active;
  assign fire   = msg_valid & msg_ready;
  assign msg_kind = kind;

  always_comb begin
    stall = |(exec_mask[CORE_NUM-1:0] & core_busy);
    unique case (1'b1)
      fence == FENCE_ACQ:
        stall = stall | (|(prev_mask & core_busy));
      fence == FENCE_REL:
        stall = stall | (|core_busy);
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state;
    mem_re    = 1'b0;
    mem_raddr = ptr;
    msg_valid = 1'b0;
    msg_data  = '0;
    msg_last  = 1'b0;
    kind      = KIND_MASK;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_n = S_HDR;
      end
      S_HDR: begin
        mem_re    = (hdr_cnt != 2'd3);
        mem_raddr = base + ADDR_W'(hdr_cnt);
        if (hdr_cnt == 2'd3) begin
          if (hdr_halt || hdr_ovf) state_n = S_DONE;
          else                     state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!stall) state_n = S_MASK;
      end
      S_MASK: begin
        msg_valid = 1'b1;
        msg_data  = exec_mask;
        if (fire) state_n = S_R0VEC;
      end
      S_R0VEC: begin
        msg_valid = 1'b1;
        msg_data  = r0_vec;
        kind      = KIND_R0VEC;
        if (fire) begin
          mem_re    = 1'b1;
          mem_raddr = base + ADDR_W'(HDR_WORDS);
          state_n   = S_R0;
        end
      end
      S_R0: begin
        msg_valid = 1'b1;
        msg_data  = rd_data;
        kind      = KIND_R0DATA;
        msg_last  = (ptr == last_r0) && (if_cnt == '0);
        if (fire) begin
          mem_re    = 1'b1;
          mem_raddr = ptr + ADDR_W'(1);
          if (ptr == last_r0) begin
            mem_raddr = base + ADDR_W'(FRAME_WORDS);
            state_n   = (if_cnt == '0) ? S_NEXT : S_IF;
          end
        end
      end
      S_IF: begin
        msg_valid = 1'b1;
        msg_data  = rd_data;
        kind      = KIND_INSTR;
        msg_last  = (ptr == last_if);
        if (fire) begin
          mem_re    = 1'b1;
          mem_raddr = ptr + ADDR_W'(1);
          if (ptr == last_if) state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        state_n = S_HDR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hdr_cnt   <= '0;
      base      <= '0;
      ptr       <= '0;
      word0     <= '0;
      exec_mask <= '0;
      r0_vec    <= '0;
      prev_mask <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      if (mem_re) ptr <= mem_raddr;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            base      <= '0;
            hdr_cnt   <= '0;
            prev_mask <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
          end
        end
        S_HDR: begin
          hdr_cnt <= hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd1) word0 <= rd_data;
          if (hdr_cnt == 2'd2) exec_mask <= rd_data;
          if (hdr_cnt == 2'd3) begin
            r0_vec <= rd_data;
            if (hdr_halt) begin
              done <= 1'b1;
            end else if (hdr_ovf) begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        S_NEXT: begin
          base      <= task_end[ADDR_W-1:0];
          prev_mask <= exec_mask[CORE_NUM-1:0];
        end
        default: ;
      endcase
    end
  end

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || (start && !active)) begin
      perf_stall_cyc <= '0;
      perf_tasks     <= '0;
    end else begin
      if (state == S_CHECK && !(&perf_stall_cyc))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (state == S_NEXT && !(&perf_tasks))
        perf_tasks <= perf_tasks + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_dispatcher.sv
// Bench for frame_dispatcher: vector table plus beat scoreboard.
// Hand sequences cover fence ACQ chaining and mid-task reset.
module tb_frame_dispatcher;

  localparam int AW  = 10;
  localparam int FW  = 16;
  localparam int R0D = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [15:0]   ld_data = '0;
  logic          start = 1'b0;
  logic [15:0]   core_busy = '0;
  logic          msg_ready = 1'b1;
  logic [15:0]   msg_data;
  logic [1:0]    msg_kind;
  logic          msg_last;
  logic          msg_valid;
  logic          active;
  logic          done;
  logic          err;
`ifdef SCHED_PERF_EN
  logic [31:0]   perf_stall_cyc;
  logic [15:0]   perf_tasks;
`endif

  frame_dispatcher dut (
    .clk       (clk),
    .reset     (reset),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .core_busy (core_busy),
    .msg_data  (msg_data),
    .msg_kind  (msg_kind),
    .msg_last  (msg_last),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .active    (active),
    .done      (done),
    .err       (err)
`ifdef SCHED_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_tasks     (perf_tasks)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int          ifc;
    int          fence;
    logic [15:0] mask;
    logic [15:0] busy;
    int          bcyc;
    bit          tog;
    bit          stall;
    bit          err;
  } vec_t;

  beat_t sb[$];
  beat_t exp_b;
  beat_t hold_b;
  vec_t  vt[8];
  int    errors = 0;
  int    checks = 0;
  int    hs_cnt = 0;
  int    r0_hs = 0;
  bit    mon_en = 1'b0;
  bit    held = 1'b0;
  bit    tog = 1'b0;

  function automatic logic [15:0] pat(int a);
    return 16'((a * 37) ^ 16'h5100);
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (held) begin
        checks++;
        if (!(msg_valid && msg_kind == hold_b.kind &&
              msg_data == hold_b.data &&
              msg_last == hold_b.last)) begin
          errors++;
          $display("FAIL hold: got v%0d k%0d d%h l%0d want k%0d d%h l%0d",
                   msg_valid, msg_kind, msg_data, msg_last,
                   hold_b.kind, hold_b.data, hold_b.last);
        end
      end
      if (msg_valid && msg_ready) begin
        hs_cnt++;
        if (msg_kind == 2'd2) r0_hs++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got k%0d d%h want none",
                   msg_kind, msg_data);
        end else begin
          exp_b = sb.pop_front();
          if (msg_kind != exp_b.kind ||
              msg_data != exp_b.data ||
              msg_last != exp_b.last) begin
            errors++;
            $display("FAIL beat%0d: got k%0d d%h l%0d want k%0d d%h l%0d",
                     hs_cnt, msg_kind, msg_data, msg_last,
                     exp_b.kind, exp_b.data, exp_b.last);
          end
        end
      end
      held   = msg_valid && !msg_ready;
      hold_b = '{msg_kind, msg_data, msg_last};
    end else begin
      held = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) msg_ready = ~msg_ready;
  endtask

  task automatic wr(int a, logic [15:0] d);
    ld_addr = AW'(a);
    ld_data = d;
    ld_we   = 1'b1;
    @(posedge clk);
    #1;
    ld_we = 1'b0;
  endtask

  task automatic load_task(int b, int ifc, int fence,
                           logic [15:0] mask,
                           logic [15:0] r0v);
    wr(b, 16'h0100 | 16'(fence << 6) | 16'(ifc));
    wr(b + 1, mask);
    wr(b + 2, r0v);
    for (int i = 3; i < FW; i++) wr(b + i, pat(b + i));
    if (b + (1 + ifc) * FW < 1024)
      for (int j = 0; j < ifc * FW; j++)
        wr(b + FW + j, pat(b + FW + j));
  endtask

  task automatic load_halt(int b);
    if (b < 1024) wr(b, 16'h0000);
  endtask

  task automatic expect_task(int b, int ifc,
                             logic [15:0] mask,
                             logic [15:0] r0v);
    sb.push_back('{2'd0, mask, 1'b0});
    sb.push_back('{2'd1, r0v, 1'b0});
    for (int i = 0; i < R0D; i++)
      sb.push_back('{2'd2, pat(b + 3 + i),
                     (ifc == 0) && (i == R0D - 1)});
    for (int j = 0; j < ifc * FW; j++)
      sb.push_back('{2'd3, pat(b + FW + j),
                     j == ifc * FW - 1});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    for (int c = 0; c < 5000; c++) begin
      if (done) break;
      tick();
    end
    chk(name, done, 1);
  endtask

  initial begin
    int first;
    int exp_first;
    int exp_n;
    vec_t v;

    vt[0] = '{1, 0, 16'h0003, 16'h0000, 0, 0, 0, 0};
    vt[1] = '{1, 0, 16'h0003, 16'h0002, 10, 0, 1, 0};
    vt[2] = '{1, 2, 16'h0003, 16'h8000, 12, 0, 1, 0};
    vt[3] = '{1, 0, 16'h0003, 16'h8000, 12, 0, 0, 0};
    vt[4] = '{1, 0, 16'h0003, 16'h0000, 0, 1, 0, 0};
    vt[5] = '{63, 0, 16'h0003, 16'h0000, 0, 0, 0, 1};
    vt[6] = '{0, 1, 16'h00F0, 16'h0001, 12, 0, 0, 0};
    vt[7] = '{2, 3, 16'h0C00, 16'h8000, 12, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", msg_valid, 0);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_data", msg_data, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      v = vt[i];
      load_task(0, v.ifc, v.fence, v.mask, 16'(16'h00A5 + i));
      load_halt((1 + v.ifc) * FW);
      sb.delete();
      hs_cnt = 0;
      if (!v.err) expect_task(0, v.ifc, v.mask, 16'(16'h00A5 + i));
      exp_n = v.err ? 0 : 2 + R0D + v.ifc * FW;
      exp_first = v.err ? -1 : (v.stall ? v.bcyc : 4);
      core_busy = (v.bcyc > 0) ? v.busy : 16'h0000;
      pulse_start();
      tog = v.tog;
      first = -1;
      for (int c = 0; c < 5000; c++) begin
        @(posedge clk);
        #1;
        if (c == 0) chk($sformatf("v%0d_done_clr", i), done, 0);
        if (msg_valid && first < 0) first = c;
        ld_we = 1'b0;
        if (c == 0) begin
          ld_addr = AW'(3);
          ld_data = 16'hDEAD;
          ld_we   = 1'b1;
        end
        if (c == v.bcyc - 1) core_busy = 16'h0000;
        if (tog) msg_ready = ~msg_ready;
        if (done) break;
      end
      ld_we = 1'b0;
      tog = 1'b0;
      msg_ready = 1'b1;
      core_busy = 16'h0000;
      repeat (2) tick();
      chk($sformatf("v%0d_first_valid", i), first, exp_first);
      chk($sformatf("v%0d_beats", i), hs_cnt, exp_n);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_err", i), err, v.err);
      chk($sformatf("v%0d_active", i), active, 0);
    end

    // ACQ fence: second task waits on cores of the first task's mask.
    load_task(0, 0, 0, 16'h0001, 16'h0011);
    load_task(16, 1, 1, 16'h0002, 16'h0022);
    load_halt(48);
    sb.delete();
    hs_cnt = 0;
    expect_task(0, 0, 16'h0001, 16'h0011);
    expect_task(16, 1, 16'h0002, 16'h0022);
    pulse_start();
    for (int c = 0; c < 200; c++) begin
      if (hs_cnt >= 10) break;
      tick();
    end
    chk("acq_first_task", hs_cnt, 10);
    core_busy = 16'h0001;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (msg_valid && first < 0) first = c;
    end
    chk("acq_stall", first, -1);
    core_busy = 16'h0000;
    tick();
    chk("acq_resume", msg_valid, 1);
    wait_done("acq_done");
    repeat (2) tick();
    chk("acq_beats", hs_cnt, 36);
    chk("acq_err", err, 0);

    // Reset while the 5th R0DATA beat is on the bus.
    load_task(0, 1, 0, 16'h0003, 16'h0077);
    load_halt(32);
    sb.delete();
    hs_cnt = 0;
    r0_hs = 0;
    expect_task(0, 1, 16'h0003, 16'h0077);
    pulse_start();
    for (int c = 0; c < 200; c++) begin
      if (r0_hs == 4 && msg_valid && msg_kind == 2'd2) break;
      tick();
    end
    chk("rst_reach_r0", r0_hs, 4);
    reset = 1'b1;
    mon_en = 1'b0;
    tick();
    chk("mid_rst_valid", msg_valid, 0);
    chk("mid_rst_data", msg_data, 0);
    chk("mid_rst_kind", msg_kind, 0);
    chk("mid_rst_last", msg_last, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    first = -1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (msg_valid && first < 0) first = c;
    end
    chk("post_rst_idle", first, -1);
    sb.delete();
    hs_cnt = 0;
    expect_task(0, 1, 16'h0003, 16'h0077);
    mon_en = 1'b1;
    pulse_start();
    wait_done("replay_done");
    repeat (2) tick();
    chk("replay_beats", hs_cnt, 26);
    chk("replay_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
